gate_truth_checker: RTL

- Self-checking stimulus/response stage wrapped around the 2-input logic-gate block.
- Drives the gate block's A/B inputs through all four input vectors.
- Samples its seven outputs after a programmable settle time and compares them against an internally computed golden truth table.
- Reports an error count, the first failing vector and the first failing bits, then signals done. Replaces hand-written monitor benches with a synthesizable on-chip checker.

---
 rtl/gate_truth_checker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// ============================================================================
// Module      : gate_truth_checker
// Description : On-chip stimulus/response checker for a 2-input gate block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [6:0]       dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic [6:0]       first_fail_bits
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [7:0]       c_settle_m1 = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       c_last_loop = 8'(LOOPS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       r_vec;
    logic [7:0]       r_loop_cnt;
    logic [7:0]       r_wait_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_err_count;
    logic [1:0]       r_first_fail_vec;
    logic [6:0]       r_first_fail_bits;

    logic [6:0]       w_expected;
    logic [6:0]       w_mism;
    logic [CNT_W-1:0] w_err_next;
    logic             w_last;

    // Golden outputs, bit order {AND, OR, XOR, NAND, NOR, XNOR, NOT(A)}
    always_comb begin
        w_expected = 7'h0F;
        case (r_vec)
            2'd0:    w_expected = 7'h0F;
            2'd1:    w_expected = 7'h39;
            2'd2:    w_expected = 7'h38;
            2'd3:    w_expected = 7'h62;
            default: w_expected = 7'h0F;
        endcase
    end

    assign w_mism = dut_out ^ w_expected;
    assign w_last = (r_vec == 2'd3) && (r_loop_cnt == c_last_loop);

    always_comb begin
        w_err_next = r_err_count;
        if ((|w_mism) && (r_err_count != c_cnt_max))
            w_err_next = r_err_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= c_st_idle;
            r_vec             <= 2'd0;
            r_loop_cnt        <= 8'd0;
            r_wait_cnt        <= 8'd0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_fail_vec  <= 2'd0;
            r_first_fail_bits <= 7'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state           <= c_st_run;
                        r_vec             <= 2'd0;
                        r_wait_cnt        <= c_settle_m1;
                        r_loop_cnt        <= 8'd0;
                        r_busy            <= 1'b1;
                        r_pass            <= 1'b0;
                        r_err_count       <= '0;
                        r_first_fail_vec  <= 2'd0;
                        r_first_fail_bits <= 7'd0;
                    end
                end
                c_st_run: begin
                    if (r_wait_cnt != 8'd0) begin
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                    end else begin
                        r_err_count <= w_err_next;
                        // A saturating count never returns to zero, so zero marks "no failure yet"
                        if ((|w_mism) && (r_err_count == '0)) begin
                            r_first_fail_vec  <= r_vec;
                            r_first_fail_bits <= w_mism;
                        end
                        if (w_last) begin
                            r_state <= c_st_done;
                            r_vec   <= 2'd0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_vec      <= r_vec + 2'd1;
                            r_wait_cnt <= c_settle_m1;
                            if (r_vec == 2'd3)
                                r_loop_cnt <= r_loop_cnt + 8'd1;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign a               = r_vec[1];
    assign b               = r_vec[0];
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_fail_vec  = r_first_fail_vec;
    assign first_fail_bits = r_first_fail_bits;

endmodule

`default_nettype wire
